note_highway: RTL
=================

# note_highway

Parametrised note-lane engine for the rhythm game, clocked on CLOCK_25. It replaces the fixed set of eight per-row pattern instances and their OR-ed score logic with one block. The block holds a pool of NUM_SLOTS falling notes across NUM_LANES lanes and advances them once per video frame. It judges player presses (colorTracker flags or KEYs) against a hit window, keeps score, combo and miss counters, and answers per-pixel sprite queries from the VGA scan position.

## Interface
- NUM_SLOTS, 8: concurrent note rows held.
- NUM_LANES, 4: lanes; a note row carries a lane mask (chords allowed).
- Y_W, 10: width of y position and next_y.
- HIT_Y, 450: y of the hit line.
- HIT_WINDOW, 8: half-width of the hit window, in pixels.
- SPEED, 4: pixels advanced per frame_tick.
- NOTE_H, 16: sprite height in pixels.
- LANE_W, 160: lane width in pixels.
- SCORE_W, 16: width of score and miss_count.
- COMBO_W, 8: width of combo and max_combo.
- CLOCK_25  in  1  block clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame; triggers the advance.
- spawn_valid  in  1  request to insert a note row.
- spawn_lanes  in  NUM_LANES  lane mask of the requested row; must be nonzero when valid.
- spawn_ready  out  1  a free slot exists.
- lane_press  in  NUM_LANES  level press per lane, already synchronous to CLOCK_25.
- next_x  in  10  VGA scan x.
- next_y  in  Y_W  VGA scan y.
- sprite  out  NUM_LANES  per-lane "note pixel here", registered.
- hit  out  1  pulse: at least one lane hit this cycle.
- miss  out  1  pulse: at least one row expired this cycle.
- score  out  SCORE_W  saturating hit count.
- miss_count  out  SCORE_W  saturating count of expired rows.
- combo  out  COMBO_W  current streak, saturating.
- max_combo  out  COMBO_W  best streak since reset.

## Operation
- Each slot holds valid, mask[NUM_LANES], and y[Y_W].
- In window: HIT_Y-HIT_WINDOW ≤ y ≤ HIT_Y+HIT_WINDOW.
- Spawn:
  - spawn_ready = OR of ~valid, combinational.
  - On spawn_valid & spawn_ready, the lowest-index free slot loads valid=1, mask=spawn_lanes, y=0.
  - A slot spawned on a frame_tick cycle is not advanced that cycle.
  - spawn_valid while not ready is ignored; the block does not store the request.
- Press:
  - Rising edge on lane L = lane_press[L] & ~prev[L]. prev resets to all-ones, so a key held through reset does not fire.
  - Each edge selects the lowest-index valid slot with mask[L]=1 that is in window, using pre-advance y.
  - The selected slot clears mask[L]. A slot whose mask reaches 0 frees (valid=0).
  - An edge that matches no slot is a ghost press.
- Advance: on frame_tick, every valid slot that remains valid after this cycle's clears does y += SPEED. If the new y > HIT_Y+HIT_WINDOW, the slot frees and counts as one expiry, regardless of how many mask bits remain.
- Counters, with hits = number of lanes matched this cycle:
  - score += hits, saturating.
  - miss_count += number of expired slots, saturating.
  - combo_next = (any expiry or any ghost) ? 0 : combo + hits, saturating.
  - max_combo = max(max_combo, combo_next).
- Sprite: sprite[L] = 1 iff some valid slot has mask[L], L == next_x / LANE_W, and y ≤ next_y < y+NOTE_H. Lanes with index ≥ NUM_LANES yield 0.

## Timing
- Reset (synchronous, rst=1 for ≥1 cycle) clears all slots and every output to 0, except spawn_ready, which is 1 once the slots are clear. Reset mid-frame discards all in-flight notes and any same-cycle spawn or press.
- Press edge to score/combo/hit: 1 cycle, all registered together.
- frame_tick to updated y, miss and miss_count: 1 cycle.
- next_x/next_y to sprite: 1 cycle; the top level aligns the pixel pipe.
- hit and miss are single-cycle pulses and may be asserted together.
- Elaboration check: HIT_Y+HIT_WINDOW+SPEED < 2^Y_W, so y never wraps.

## Structure
- Package note_highway_pkg holds the slot typedef (valid, mask, y), the window-bound constants, and a popcount function.
- Sub-module note_slot, one instance per slot, handles load, lane clear, advance, expiry flag, in-window flags and the sprite compare.
- The top of the block does the priority select per lane, the free-slot priority encode, the edge detection and the counters.

## Test plan
- Spawn mask 4'b0001, apply 111 frame_ticks (y=444), press lane 0 → after 1 cycle hit=1, score=1, combo=1, slot freed, spawn_ready=1.
- Spawn 4'b0001 with no press → ticks 1–114 no miss (y=456); tick 115 → miss pulse, miss_count=1, combo=0.
- Chord 4'b0101 at y=448, press lanes 0 and 2 in the same cycle → score +2, combo +2, slot freed; press only lane 0 → slot stays with mask 4'b0100.
- Spawn 8 rows → spawn_ready=0; 9th spawn_valid ignored; free one slot by hit → the next spawn lands in that slot index.
- Slot y=100, lane 2: next_x=330, next_y=105 → sprite=4'b0100 one cycle later; next_y=116 → 0; ghost press on lane 3 with combo=5 → combo=0, score unchanged.
- lane_press=4'b1111 held through rst, then release rst → no hits; rst asserted with 3 live notes → all cleared, counters 0 the next cycle.

Source files
------------

// File: rtl/note_highway_pkg.sv
// note_highway_pkg
// Shared types and helpers for the note-lane engine.
//   LANES / COORD_W : lane count and y-coordinate width of a note slot
//   slot_t          : one falling note row (valid, lane mask, y position)
//   win_lo / win_hi : inclusive bounds of the hit window around the hit line
//   popcount        : number of set bits in a 32-bit vector
package note_highway_pkg;

   localparam int LANES   = 4;
   localparam int COORD_W = 10;

   typedef struct packed {
      logic               valid;
      logic [LANES-1:0]   mask;
      logic [COORD_W-1:0] y;
   } slot_t;

   // Clamp at zero so a hit line close to the top cannot go negative.
   function automatic int win_lo(input int hit_y, input int half);
      return (hit_y > half) ? (hit_y - half) : 0;
   endfunction

   function automatic int win_hi(input int hit_y, input int half);
      return hit_y + half;
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/note_highway_if.sv
// note_highway_if
// Bundle between the game logic (master) and the note engine (slave).
//   frame_tick, spawn_valid/spawn_lanes, lane_press, next_x/next_y : master -> engine
//   spawn_ready, sprite, hit, miss, score, miss_count, combo,
//   max_combo                                                      : engine -> master
interface note_highway_if #(
   parameter int NUM_LANES = 4,
   parameter int Y_W       = 10,
   parameter int SCORE_W   = 16,
   parameter int COMBO_W   = 8
);
   logic                 frame_tick;
   logic                 spawn_valid;
   logic [NUM_LANES-1:0] spawn_lanes;
   logic                 spawn_ready;
   logic [NUM_LANES-1:0] lane_press;
   logic [9:0]           next_x;
   logic [Y_W-1:0]       next_y;
   logic [NUM_LANES-1:0] sprite;
   logic                 hit;
   logic                 miss;
   logic [SCORE_W-1:0]   score;
   logic [SCORE_W-1:0]   miss_count;
   logic [COMBO_W-1:0]   combo;
   logic [COMBO_W-1:0]   max_combo;

   modport master (
      output frame_tick, spawn_valid, spawn_lanes, lane_press, next_x, next_y,
      input  spawn_ready, sprite, hit, miss, score, miss_count, combo, max_combo
   );

   modport slave (
      input  frame_tick, spawn_valid, spawn_lanes, lane_press, next_x, next_y,
      output spawn_ready, sprite, hit, miss, score, miss_count, combo, max_combo
   );
endinterface

// File: rtl/note_slot.sv
// note_slot
// One falling note row: load, per-lane clear, per-frame advance and expiry.
//   CLOCK_25, rst : clock, synchronous active-high reset
//   load          : take load_mask as a fresh row at y=0 (slot must be free)
//   clr_mask      : lanes hit this cycle; an empty mask frees the slot
//   tick          : frame advance by SPEED pixels
//   pix_y         : scan line for the sprite compare
//   slot          : registered slot state
//   in_window     : valid and y within the hit window (pre-advance)
//   expire        : this cycle's advance pushes the row past the window
//   pix_lanes     : mask of this row if pix_y falls inside its sprite
module note_slot
   import note_highway_pkg::*;
#(
   parameter int HIT_Y      = 450,
   parameter int HIT_WINDOW = 8,
   parameter int SPEED      = 4,
   parameter int NOTE_H     = 16
) (
   input  logic               CLOCK_25,
   input  logic               rst,
   input  logic               load,
   input  logic [LANES-1:0]   load_mask,
   input  logic [LANES-1:0]   clr_mask,
   input  logic               tick,
   input  logic [COORD_W-1:0] pix_y,
   output slot_t              slot,
   output logic               in_window,
   output logic               expire,
   output logic [LANES-1:0]   pix_lanes
);

   localparam logic [COORD_W:0] WIN_LO = (COORD_W+1)'(win_lo(HIT_Y, HIT_WINDOW));
   localparam logic [COORD_W:0] WIN_HI = (COORD_W+1)'(win_hi(HIT_Y, HIT_WINDOW));

   slot_t              slot_reg;
   slot_t              slot_next;
   logic [LANES-1:0]   kept_mask;
   logic [COORD_W:0]   y_adv;
   logic [COORD_W:0]   y_ext;
   logic [COORD_W:0]   pix_ext;

   assign y_ext   = {1'b0, slot_reg.y};
   assign pix_ext = {1'b0, pix_y};

   always_comb begin
      slot_next = slot_reg;
      expire    = 1'b0;
      kept_mask = slot_reg.mask & ~clr_mask;
      y_adv     = y_ext + (COORD_W+1)'(SPEED);
      if (load) begin
         slot_next.valid = 1'b1;
         slot_next.mask  = load_mask;
         slot_next.y     = '0;
      end else if (slot_reg.valid) begin
         slot_next.mask = kept_mask;
         if (kept_mask == '0) begin
            // Last lane hit: row is done, no advance and no expiry.
            slot_next = '0;
         end else if (tick) begin
            if (y_adv > WIN_HI) begin
               expire    = 1'b1;
               slot_next = '0;
            end else begin
               slot_next.y = y_adv[COORD_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge CLOCK_25) begin
      if (rst) begin
         slot_reg <= '0;
      end else begin
         slot_reg <= slot_next;
      end
   end

   assign slot      = slot_reg;
   assign in_window = slot_reg.valid && (y_ext >= WIN_LO) && (y_ext <= WIN_HI);
   assign pix_lanes = (slot_reg.valid && (pix_ext >= y_ext) &&
                       (pix_ext < y_ext + (COORD_W+1)'(NOTE_H))) ? slot_reg.mask : '0;

endmodule

// File: rtl/note_highway.sv
// note_highway
// Note-lane engine: a pool of NUM_SLOTS falling rows over NUM_LANES lanes,
// advanced once per frame, judged against player presses, with score/combo
// bookkeeping and a registered per-pixel sprite lookup.
//   CLOCK_25 : clock
//   rst      : synchronous active-high reset
//   bus      : note_highway_if slave (spawn handshake, presses, scan
//              position in; sprite, hit/miss pulses and counters out)
module note_highway
   import note_highway_pkg::*;
#(
   parameter int NUM_SLOTS  = 8,
   parameter int NUM_LANES  = LANES,
   parameter int Y_W        = COORD_W,
   parameter int HIT_Y      = 450,
   parameter int HIT_WINDOW = 8,
   parameter int SPEED      = 4,
   parameter int NOTE_H     = 16,
   parameter int LANE_W     = 160,
   parameter int SCORE_W    = 16,
   parameter int COMBO_W    = 8
) (
   input logic            CLOCK_25,
   input logic            rst,
   note_highway_if.slave  bus
);

   // Slot storage is typed from the package, so widths must agree with it.
   if (NUM_LANES != LANES || Y_W != COORD_W) begin : g_bad_width
      $error("note_highway: NUM_LANES/Y_W must match note_highway_pkg");
   end
   if (HIT_Y + HIT_WINDOW + SPEED >= (1 << Y_W)) begin : g_bad_range
      $error("note_highway: y would wrap before expiring");
   end
   if (NUM_SLOTS > 32) begin : g_bad_slots
      $error("note_highway: NUM_SLOTS above popcount width");
   end

   slot_t                slot [NUM_SLOTS];
   logic [NUM_LANES-1:0] clr_mask [NUM_SLOTS];
   logic [NUM_LANES-1:0] pix_lanes [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] valid_vec;
   logic [NUM_SLOTS-1:0] win_vec;
   logic [NUM_SLOTS-1:0] load_vec;
   logic [NUM_SLOTS-1:0] expire_vec;

   logic [NUM_LANES-1:0] prev_reg;
   logic [NUM_LANES-1:0] press_edge;
   logic [NUM_LANES-1:0] matched;
   logic [NUM_LANES-1:0] ghost;
   logic [NUM_LANES-1:0] lane_pix;
   logic [NUM_LANES-1:0] sprite_next;
   logic [NUM_LANES-1:0] sprite_reg;
   logic [9:0]           lane_idx;
   logic                 found;

   logic [SCORE_W-1:0]   score_reg, score_next;
   logic [SCORE_W-1:0]   miss_cnt_reg, miss_cnt_next;
   logic [COMBO_W-1:0]   combo_reg, combo_next;
   logic [COMBO_W-1:0]   max_combo_reg, max_combo_next;
   logic                 hit_reg, miss_reg;
   logic [SCORE_W:0]     score_sum, miss_sum;
   logic [COMBO_W:0]     combo_sum;
   int unsigned          hits, expiries;

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      note_slot #(
         .HIT_Y      (HIT_Y),
         .HIT_WINDOW (HIT_WINDOW),
         .SPEED      (SPEED),
         .NOTE_H     (NOTE_H)
      ) u_slot (
         .CLOCK_25  (CLOCK_25),
         .rst       (rst),
         .load      (load_vec[gi]),
         .load_mask (bus.spawn_lanes),
         .clr_mask  (clr_mask[gi]),
         .tick      (bus.frame_tick),
         .pix_y     (bus.next_y),
         .slot      (slot[gi]),
         .in_window (win_vec[gi]),
         .expire    (expire_vec[gi]),
         .pix_lanes (pix_lanes[gi])
      );
      assign valid_vec[gi] = slot[gi].valid;
   end

   assign press_edge      = bus.lane_press & ~prev_reg;
   assign bus.spawn_ready = ~&valid_vec;

   // Per lane, the lowest-index in-window slot carrying that lane takes the edge.
   always_comb begin
      matched = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         clr_mask[s] = '0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (press_edge[l] && !matched[l] && win_vec[s] && slot[s].mask[l]) begin
               clr_mask[s][l] = 1'b1;
               matched[l]     = 1'b1;
            end
         end
      end
   end

   assign ghost = press_edge & ~matched;

   // Lowest free slot takes the spawn; a request with no free slot is dropped.
   always_comb begin
      load_vec = '0;
      found    = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (!valid_vec[s] && !found) begin
            load_vec[s] = bus.spawn_valid;
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      hits      = popcount(32'(matched));
      expiries  = popcount(32'(expire_vec));
      score_sum = {1'b0, score_reg} + (SCORE_W+1)'(hits);
      miss_sum  = {1'b0, miss_cnt_reg} + (SCORE_W+1)'(expiries);
      combo_sum = {1'b0, combo_reg} + (COMBO_W+1)'(hits);

      score_next    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      miss_cnt_next = miss_sum[SCORE_W]  ? '1 : miss_sum[SCORE_W-1:0];
      if ((|expire_vec) || (|ghost)) begin
         combo_next = '0;
      end else begin
         combo_next = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
      end
      max_combo_next = (combo_next > max_combo_reg) ? combo_next : max_combo_reg;
   end

   // Sprite: lane from scan x, row hit from each slot's compare.
   assign lane_idx = bus.next_x / 10'(LANE_W);

   always_comb begin
      lane_pix = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         lane_pix = lane_pix | pix_lanes[s];
      end
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign sprite_next[gi] = lane_pix[gi] && (lane_idx == 10'(gi));
   end

   always_ff @(posedge CLOCK_25) begin
      if (rst) begin
         prev_reg      <= '1;   // a key held through reset must not fire
         score_reg     <= '0;
         miss_cnt_reg  <= '0;
         combo_reg     <= '0;
         max_combo_reg <= '0;
         hit_reg       <= 1'b0;
         miss_reg      <= 1'b0;
         sprite_reg    <= '0;
      end else begin
         prev_reg      <= bus.lane_press;
         score_reg     <= score_next;
         miss_cnt_reg  <= miss_cnt_next;
         combo_reg     <= combo_next;
         max_combo_reg <= max_combo_next;
         hit_reg       <= |matched;
         miss_reg      <= |expire_vec;
         sprite_reg    <= sprite_next;
      end
   end

   assign bus.sprite     = sprite_reg;
   assign bus.hit        = hit_reg;
   assign bus.miss       = miss_reg;
   assign bus.score      = score_reg;
   assign bus.miss_count = miss_cnt_reg;
   assign bus.combo      = combo_reg;
   assign bus.max_combo  = max_combo_reg;

endmodule
